// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_pkg
// Brief    : Shared encodings and helpers for the MEM/WB write-back stage.
// Revision : 1.0
// ============================================================================
package writeback_stage_pkg;

    localparam int WB_SEL_W  = 2;
    localparam int LD_TYPE_W = 3;
    localparam int ADDR_LO_W = 2;

    // Encoding 3 is reserved and falls back to the ALU result.
    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    // Encodings 5-7 are reserved and behave as a full-word load.
    typedef enum logic [LD_TYPE_W-1:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } load_type_e;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_if
// Brief    : MEM-to-WB bundle plus the register-file write port and retire count.
// Revision : 1.0
// ============================================================================
interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 32
);
    logic                  stall;
    logic                  flush;
    logic                  mem_valid;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic [WB_SEL_W-1:0]   mem_wb_sel;
    logic [LD_TYPE_W-1:0]  mem_load_type;
    logic [ADDR_LO_W-1:0]  mem_addr_lo;
    logic [DATA_W-1:0]     mem_alu_result;
    logic [DATA_W-1:0]     mem_load_data;
    logic [DATA_W-1:0]     mem_pc_plus8;

    logic                  write_en;
    logic [REG_ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0]     data_d;
    logic                  wb_valid;
    logic [COUNT_W-1:0]    retire_count;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_dest, mem_wb_sel,
               mem_load_type, mem_addr_lo, mem_alu_result, mem_load_data, mem_pc_plus8,
        input  write_en, addr_d, data_d, wb_valid, retire_count
    );

    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_dest, mem_wb_sel,
               mem_load_type, mem_addr_lo, mem_alu_result, mem_load_data, mem_pc_plus8,
        output write_en, addr_d, data_d, wb_valid, retire_count
    );

endinterface
`default_nettype wire

// File: rtl/writeback_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_load_align
// Brief    : Extracts and extends the byte/halfword/word a load asked for.
// Revision : 1.0
// ============================================================================
module writeback_stage_load_align
    import writeback_stage_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [31:0]          word,
    input  logic [ADDR_LO_W-1:0] addr_lo,
    input  logic [LD_TYPE_W-1:0] load_type,
    output logic [31:0]          result
);

    localparam bit C_BE = (BIG_ENDIAN != 0);

    logic [1:0]  byte_sel;
    logic        half_sel;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Big-endian lane k sits at lane (3-k) of the little-endian layout.
    always_comb begin
        byte_sel = C_BE ? ~addr_lo : addr_lo;
        half_sel = C_BE ? ~addr_lo[1] : addr_lo[1];
        byte_val = word[{byte_sel, 3'b000} +: 8];
        half_val = word[{half_sel, 4'b0000} +: 16];
        case (load_type_e'(load_type))
            LD_H:    result = ext16(half_val, 1'b1);
            LD_HU:   result = ext16(half_val, 1'b0);
            LD_B:    result = ext8(byte_val, 1'b1);
            LD_BU:   result = ext8(byte_val, 1'b0);
            default: result = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : MEM/WB pipeline register, write-back select and retire counter.
// Revision : 1.0
// ============================================================================
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BIG_ENDIAN = 0,
    parameter int COUNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    writeback_stage_if.slave wb
);

    logic [31:0]           load_result;
    logic [DATA_W-1:0]     sel_data;
    logic                  capture;

    logic                  valid_q,    valid_d;
    logic                  write_en_q, write_en_d;
    logic [REG_ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0]     data_q,     data_d;
    logic [COUNT_W-1:0]    count_q,    count_d;

    writeback_stage_load_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_align (
        .word      (wb.mem_load_data),
        .addr_lo   (wb.mem_addr_lo),
        .load_type (wb.mem_load_type),
        .result    (load_result)
    );

    always_comb begin
        case (wb_sel_e'(wb.mem_wb_sel))
            WB_LOAD: sel_data = load_result;
            WB_LINK: sel_data = wb.mem_pc_plus8;
            default: sel_data = wb.mem_alu_result;
        endcase
    end

    // A stalled or flushed cycle leaves a bubble but keeps the last address/data.
    always_comb begin
        capture    = !wb.flush && !wb.stall;
        valid_d    = 1'b0;
        write_en_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        count_d    = count_q;
        if (capture) begin
            valid_d    = wb.mem_valid;
            write_en_d = wb.mem_valid && wb.mem_reg_write && (wb.mem_dest != '0);
            addr_d     = wb.mem_dest;
            data_d     = sel_data;
            if (wb.mem_valid) begin
                count_d = count_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            write_en_q <= write_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
        end
    end

    assign wb.wb_valid     = valid_q;
    assign wb.write_en     = write_en_q;
    assign wb.addr_d       = addr_q;
    assign wb.data_d       = data_q;
    assign wb.retire_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Scoreboard bench for writeback_stage (little- and big-endian copies).
// Revision : 1.0
// ============================================================================
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if #(.COUNT_W(32)) if_le ();
    writeback_stage_if #(.COUNT_W(4))  if_be ();

    // The big-endian copy sees the same stimulus; it also has a 4-bit counter so wrap is reachable.
    assign if_be.stall          = if_le.stall;
    assign if_be.flush          = if_le.flush;
    assign if_be.mem_valid      = if_le.mem_valid;
    assign if_be.mem_reg_write  = if_le.mem_reg_write;
    assign if_be.mem_dest       = if_le.mem_dest;
    assign if_be.mem_wb_sel     = if_le.mem_wb_sel;
    assign if_be.mem_load_type  = if_le.mem_load_type;
    assign if_be.mem_addr_lo    = if_le.mem_addr_lo;
    assign if_be.mem_alu_result = if_le.mem_alu_result;
    assign if_be.mem_load_data  = if_le.mem_load_data;
    assign if_be.mem_pc_plus8   = if_le.mem_pc_plus8;

    writeback_stage #(.BIG_ENDIAN(0), .COUNT_W(32)) u_le (
        .clk   (clk),
        .reset (rst_n),
        .wb    (if_le)
    );

    writeback_stage #(.BIG_ENDIAN(1), .COUNT_W(4)) u_be (
        .clk   (clk),
        .reset (rst_n),
        .wb    (if_be)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        valid;
        logic [31:0] cnt;
        logic [31:0] data_b;
        logic [3:0]  cnt_b;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0]  m_addr   = '0;
    logic [31:0] m_data   = '0;
    logic [31:0] m_data_b = '0;
    logic [31:0] m_cnt    = '0;
    logic [3:0]  m_cnt_b  = '0;

    // Drive one MEM-stage cycle and queue what WB must show after the next posedge.
    task automatic drive(input logic v, input logic rw, input logic [4:0] dest,
                         input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc8,
                         input logic st, input logic fl,
                         input logic [31:0] xd, input logic [31:0] xdb);
        exp_t e;
        @(negedge clk);
        if_le.mem_valid      = v;
        if_le.mem_reg_write  = rw;
        if_le.mem_dest       = dest;
        if_le.mem_wb_sel     = sel;
        if_le.mem_load_type  = lt;
        if_le.mem_addr_lo    = lo;
        if_le.mem_alu_result = alu;
        if_le.mem_load_data  = ld;
        if_le.mem_pc_plus8   = pc8;
        if_le.stall          = st;
        if_le.flush          = fl;
        if (!rst_n) begin
            m_addr = '0; m_data = '0; m_data_b = '0; m_cnt = '0; m_cnt_b = '0;
            e.we = 1'b0; e.valid = 1'b0;
        end else if (fl || st) begin
            e.we = 1'b0; e.valid = 1'b0;
        end else begin
            m_addr   = dest;
            m_data   = xd;
            m_data_b = xdb;
            if (v) begin
                m_cnt   = m_cnt + 32'd1;
                m_cnt_b = m_cnt_b + 4'd1;
            end
            e.we    = v && rw && (dest != 5'd0);
            e.valid = v;
        end
        e.addr = m_addr; e.data = m_data; e.data_b = m_data_b;
        e.cnt  = m_cnt;  e.cnt_b = m_cnt_b;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks += 5;
            if (if_le.write_en !== mon_e.we)
                $display("FAIL write_en: got %b expected %b", if_le.write_en, mon_e.we);
            else n_pass++;
            if (if_le.addr_d !== mon_e.addr)
                $display("FAIL addr_d: got %0d expected %0d", if_le.addr_d, mon_e.addr);
            else n_pass++;
            if (if_le.data_d !== mon_e.data)
                $display("FAIL data_d: got %h expected %h", if_le.data_d, mon_e.data);
            else n_pass++;
            if (if_le.wb_valid !== mon_e.valid)
                $display("FAIL wb_valid: got %b expected %b", if_le.wb_valid, mon_e.valid);
            else n_pass++;
            if (if_le.retire_count !== mon_e.cnt)
                $display("FAIL retire_count: got %h expected %h", if_le.retire_count, mon_e.cnt);
            else n_pass++;
            n_checks += 2;
            if (if_be.data_d !== mon_e.data_b)
                $display("FAIL be_data_d: got %h expected %h", if_be.data_d, mon_e.data_b);
            else n_pass++;
            if (if_be.retire_count !== mon_e.cnt_b)
                $display("FAIL be_retire_count: got %h expected %h", if_be.retire_count, mon_e.cnt_b);
            else n_pass++;
        end
    end

    localparam logic [31:0] C_LW = 32'h8081_7F01;

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        drive(1, 1, 5'd6, 2'd0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        n_checks++;
        if (if_le.write_en !== 1'b0 || if_le.data_d !== 32'h0 || if_le.retire_count !== 32'h0)
            $display("FAIL reset_hold: got we=%b data=%h cnt=%h expected 0/0/0",
                     if_le.write_en, if_le.data_d, if_le.retire_count);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        drive(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 0,
              32'h1234_5678, 32'h1234_5678);
        n_checks++;
        if (if_le.write_en !== 1'b1 || if_le.retire_count !== 32'd1)
            $display("FAIL alu_first_capture: got we=%b cnt=%0d expected we=1 cnt=1",
                     if_le.write_en, if_le.retire_count);
        else n_pass++;
        // Reserved select value behaves as ALU.
        drive(1, 1, 5'd3, 2'd3, 3'd0, 2'd0, 32'hA5A5_0001, 32'h1111_1111, 32'h2222_2222, 0, 0,
              32'hA5A5_0001, 32'hA5A5_0001);
    endtask

    task automatic test_r0();
        drive(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0,
              32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (if_le.write_en !== 1'b0 || if_le.wb_valid !== 1'b1)
            $display("FAIL r0_no_write: got we=%b valid=%b expected we=0 valid=1",
                     if_le.write_en, if_le.wb_valid);
        else n_pass++;
        // Valid instruction that writes nothing still retires.
        drive(1, 0, 5'd8, 2'd0, 3'd0, 2'd0, 32'h0000_0042, 32'h0, 32'h0, 0, 0,
              32'h0000_0042, 32'h0000_0042);
        // Invalid slot neither writes nor retires.
        drive(0, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h0000_0043, 32'h0, 32'h0, 0, 0,
              32'h0000_0043, 32'h0000_0043);
    endtask

    task automatic test_load();
        drive(1, 1, 5'd10, 2'd1, 3'd3, 2'd1, 32'h0, C_LW, 32'h0, 0, 0, 32'h0000_007F, 32'hFFFF_FF81);
        drive(1, 1, 5'd10, 2'd1, 3'd3, 2'd3, 32'h0, C_LW, 32'h0, 0, 0, 32'hFFFF_FF80, 32'h0000_0001);
        drive(1, 1, 5'd11, 2'd1, 3'd4, 2'd2, 32'h0, C_LW, 32'h0, 0, 0, 32'h0000_0081, 32'h0000_007F);
        drive(1, 1, 5'd12, 2'd1, 3'd1, 2'd2, 32'h0, C_LW, 32'h0, 0, 0, 32'hFFFF_8081, 32'h0000_7F01);
        drive(1, 1, 5'd13, 2'd1, 3'd2, 2'd0, 32'h0, C_LW, 32'h0, 0, 0, 32'h0000_7F01, 32'h0000_8081);
        drive(1, 1, 5'd14, 2'd1, 3'd3, 2'd0, 32'h0, C_LW, 32'h0, 0, 0, 32'h0000_0001, 32'hFFFF_FF80);
        drive(1, 1, 5'd15, 2'd1, 3'd0, 2'd3, 32'h0, C_LW, 32'h0, 0, 0, C_LW, C_LW);
        drive(1, 1, 5'd16, 2'd1, 3'd1, 2'd1, 32'h0, C_LW, 32'h0, 0, 0, 32'h0000_7F01, 32'hFFFF_8081);
        drive(1, 1, 5'd17, 2'd1, 3'd7, 2'd2, 32'h0, C_LW, 32'h0, 0, 0, C_LW, C_LW);
    endtask

    task automatic test_link_stall();
        logic [31:0] cnt_before;
        drive(1, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0040_0010, 0, 0,
              32'h0040_0010, 32'h0040_0010);
        cnt_before = m_cnt;
        drive(1, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0040_0010, 1, 0,
              32'h0, 32'h0);
        n_checks++;
        if (if_le.wb_valid !== 1'b0 || if_le.retire_count !== cnt_before)
            $display("FAIL stall_bubble: got valid=%b cnt=%0d expected valid=0 cnt=%0d",
                     if_le.wb_valid, if_le.retire_count, cnt_before);
        else n_pass++;
    endtask

    task automatic test_flush_stall();
        drive(1, 1, 5'd20, 2'd0, 3'd0, 2'd0, 32'h5555_AAAA, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0);
        drive(1, 1, 5'd21, 2'd0, 3'd0, 2'd0, 32'h6666_BBBB, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0);
        n_checks++;
        if (if_le.write_en !== 1'b0 || if_le.addr_d !== 5'd31)
            $display("FAIL flush_bubble: got we=%b addr=%0d expected we=0 addr=31",
                     if_le.write_en, if_le.addr_d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 32'h0000_0001, 32'h0000_0001);
        drive(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h0000_0002, 32'h0, 32'h0, 0, 0, 32'h0000_0002, 32'h0000_0002);
        drive(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 32'h0000_0003, 32'h0000_0003);
    endtask

    task automatic test_reset_midstream();
        drive(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h0BAD_CAFE, 32'h0, 32'h0, 0, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
        rst_n = 1'b0;
        drive(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h0BAD_CAFE, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        n_checks++;
        if (if_le.write_en !== 1'b0)
            $display("FAIL reset_midstream: got we=%b expected 0", if_le.write_en);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++)
            drive(1, 0, 5'd1, 2'd0, 3'd0, 2'd0, 32'(i), 32'h0, 32'h0, 0, 0, 32'(i), 32'(i));
        drive(1, 1, 5'd2, 2'd0, 3'd0, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0);
        n_checks++;
        if (if_be.retire_count !== 4'hF)
            $display("FAIL wrap_hold: got %h expected f", if_be.retire_count);
        else n_pass++;
        drive(1, 1, 5'd2, 2'd0, 3'd0, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 0, 0,
              32'h7777_7777, 32'h7777_7777);
        n_checks++;
        if (if_be.retire_count !== 4'h0)
            $display("FAIL wrap_zero: got %h expected 0", if_be.retire_count);
        else n_pass++;
    endtask

    initial begin
        if_le.stall = 0; if_le.flush = 0; if_le.mem_valid = 0; if_le.mem_reg_write = 0;
        if_le.mem_dest = '0; if_le.mem_wb_sel = '0; if_le.mem_load_type = '0;
        if_le.mem_addr_lo = '0; if_le.mem_alu_result = '0; if_le.mem_load_data = '0;
        if_le.mem_pc_plus8 = '0;
        test_reset();
        test_alu();
        test_r0();
        test_load();
        test_link_stall();
        test_flush_stall();
        test_back_to_back();
        test_reset_midstream();
        test_wrap();
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
